// File: rtl/sdc_host_arb.sv
// rtl/sdc_host_arb.sv - round-robin arbiter sharing the sdc_top host port; optional watchdog via SDC_ARB_WDOG_EN
module sdc_host_arb #(
    parameter int NUM_REQ  = 4,
    parameter int AW       = 22,
    parameter int DW       = 32,
    parameter int WDOG_CYC = 255
) (
    input  logic                 mclk,
    input  logic                 s_reset,
    input  logic [NUM_REQ-1:0]   hreq,
    input  logic [NUM_REQ*AW-1:0] hadr,
    input  logic [2*NUM_REQ-1:0] hlen,
    input  logic [NUM_REQ-1:0]   hwr_n,
    input  logic [NUM_REQ*DW-1:0] hwr_data,
    input  logic [4*NUM_REQ-1:0] hwr_en_n,
    output logic [NUM_REQ-1:0]   hack,
    output logic [NUM_REQ-1:0]   hwr_next,
    output logic [NUM_REQ-1:0]   hrd_valid,
    output logic [DW-1:0]        hrd_data,
    output logic [NUM_REQ-1:0]   hgnt,
    output logic                 sdr_req,
    output logic [AW-1:0]        sdr_req_adr,
    output logic [1:0]           sdr_req_len,
    output logic                 sdr_req_wr_n,
    output logic [DW-1:0]        sdr_wr_data,
    output logic [3:0]           sdr_wr_en_n,
    input  logic                 sdr_req_ack,
    input  logic                 sdr_wr_next,
    input  logic                 sdr_rd_valid,
    input  logic                 sdr_init_done,
    input  logic [DW-1:0]        sdr_rd_data,
    output logic                 err_spur,
    output logic                 err_tmo
);

    localparam int LW = $clog2(NUM_REQ);
    localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYC);

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

    state_t        state;
    logic [LW-1:0] last;
    logic [LW-1:0] gidx;
    logic [LW-1:0] sel;
    logic          sel_vld;
    logic [1:0]    cnt;
    logic          wr_q;
    logic          beat;
    logic          spur;
    logic          tmo;
    logic          fin;
    logic          gnt_any;

    // Round-robin pick: nearest requester above the last served port, wrapping
    always_comb begin
        int j;
        j       = 0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = int'(last) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (hreq[j]) begin
                sel     = LW'(j);
                sel_vld = 1'b1;
            end
        end
    end

    assign beat    = (state == WDATA && sdr_wr_next) || (state == RDATA && sdr_rd_valid);
    assign spur    = (sdr_wr_next && state != WDATA) || (sdr_rd_valid && state != RDATA);
    assign fin     = (state != IDLE) && (tmo || (beat && cnt == 2'd0));
    assign gnt_any = |hgnt;

    assign sdr_req      = (state == REQ);
    assign sdr_req_adr  = gnt_any ? hadr[int'(gidx)*AW +: AW] : '0;
    assign sdr_req_len  = gnt_any ? hlen[int'(gidx)*2 +: 2] : '0;
    assign sdr_req_wr_n = gnt_any ? hwr_n[gidx] : 1'b0;
    assign sdr_wr_data  = gnt_any ? hwr_data[int'(gidx)*DW +: DW] : '0;
    assign sdr_wr_en_n  = gnt_any ? hwr_en_n[int'(gidx)*4 +: 4] : '0;
    assign hrd_data     = sdr_rd_data;

    // Route handshakes from sdc_top back to the granted requester only
    always_comb begin
        hack      = '0;
        hwr_next  = '0;
        hrd_valid = '0;
        if (state == REQ && !tmo) hack[gidx] = sdr_req_ack;
        if (state == WDATA) hwr_next[gidx] = sdr_wr_next;
        if (state == RDATA) hrd_valid[gidx] = sdr_rd_valid;
    end

    // Transaction FSM: grant, request handshake, beat counting, release
    always_ff @(posedge mclk) begin
        if (s_reset) begin
            state    <= IDLE;
            hgnt     <= '0;
            gidx     <= '0;
            last     <= LW'(NUM_REQ - 1);
            cnt      <= 2'd0;
            wr_q     <= 1'b0;
            err_spur <= 1'b0;
        end else begin
            if (spur) err_spur <= 1'b1;
            if (fin) begin
                state <= IDLE;
                hgnt  <= '0;
                last  <= gidx;
            end else begin
                case (state)
                    IDLE: if (sdr_init_done && sel_vld) begin
                        hgnt  <= NUM_REQ'(1) << sel;
                        gidx  <= sel;
                        cnt   <= hlen[int'(sel)*2 +: 2];
                        wr_q  <= hwr_n[sel];
                        state <= REQ;
                    end
                    REQ: if (sdr_req_ack) state <= wr_q ? RDATA : WDATA;
                    default: if (beat) cnt <= cnt - 2'd1;
                endcase
            end
        end
    end

`ifdef SDC_ARB_WDOG_EN
    logic [7:0] wdog;

    assign tmo = (state != IDLE) && (wdog == WDOG_LIM);

    // Watchdog: counts idle cycles of an open transaction, aborts on the limit
    always_ff @(posedge mclk) begin
        if (s_reset) begin
            wdog    <= 8'd0;
            err_tmo <= 1'b0;
        end else begin
            if (tmo) err_tmo <= 1'b1;
            if (state == IDLE || beat || tmo) wdog <= 8'd0;
            else wdog <= wdog + 8'd1;
        end
    end
`else
    logic unused_wdog;

    assign tmo         = 1'b0;
    assign err_tmo     = 1'b0;
    assign unused_wdog = ^WDOG_LIM;
`endif

endmodule

// File: tb/tb_sdc_host_arb.sv
// tb/tb_sdc_host_arb.sv - directed self-checking bench for sdc_host_arb
module tb_sdc_host_arb;
    localparam int NUM_REQ = 4;
    localparam int AW = 22;
    localparam int DW = 32;

    logic mclk = 1'b0;
    logic s_reset;
    logic [3:0] hreq, hwr_n;
    logic [NUM_REQ*AW-1:0] hadr;
    logic [7:0] hlen;
    logic [NUM_REQ*DW-1:0] hwr_data;
    logic [15:0] hwr_en_n;
    logic [3:0] hack, hwr_next, hrd_valid, hgnt;
    logic [DW-1:0] hrd_data, sdr_wr_data, sdr_rd_data;
    logic sdr_req, sdr_req_wr_n, sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_init_done;
    logic [AW-1:0] sdr_req_adr;
    logic [1:0] sdr_req_len;
    logic [3:0] sdr_wr_en_n;
    logic err_spur, err_tmo;
    int checks = 0;
    int errors = 0;

    sdc_host_arb #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .WDOG_CYC(255)) dut (
        .mclk(mclk), .s_reset(s_reset), .hreq(hreq), .hadr(hadr), .hlen(hlen),
        .hwr_n(hwr_n), .hwr_data(hwr_data), .hwr_en_n(hwr_en_n), .hack(hack),
        .hwr_next(hwr_next), .hrd_valid(hrd_valid), .hrd_data(hrd_data), .hgnt(hgnt),
        .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
        .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
        .sdr_req_ack(sdr_req_ack), .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid),
        .sdr_init_done(sdr_init_done), .sdr_rd_data(sdr_rd_data),
        .err_spur(err_spur), .err_tmo(err_tmo)
    );

    always #5 mclk = ~mclk;

    task automatic cyc();
        @(posedge mclk);
        #1;
    endtask

    task automatic reset_dut();
        s_reset = 1'b1;
        hreq = '0; hadr = '0; hlen = '0; hwr_n = '0; hwr_data = '0; hwr_en_n = '0;
        sdr_req_ack = 1'b0; sdr_wr_next = 1'b0; sdr_rd_valid = 1'b0;
        sdr_init_done = 1'b1; sdr_rd_data = '0;
        cyc(); cyc();
        s_reset = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        #2;
        checks++; if (hgnt !== 4'b0) begin errors++; $display("FAIL reset_hgnt: got %b expected 0000", hgnt); end
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL reset_sdr_req: got %b expected 0", sdr_req); end
        checks++; if ({hack, hwr_next, hrd_valid} !== 12'b0) begin errors++; $display("FAIL reset_routes: got %h expected 000", {hack, hwr_next, hrd_valid}); end
        checks++; if (sdr_req_adr !== 22'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", sdr_req_adr); end
        checks++; if ({err_spur, err_tmo} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {err_spur, err_tmo}); end
    endtask

    task automatic test_single_write();
        cyc();
        hreq = 4'b0010; hadr[1*AW +: AW] = 22'h000100; hlen[2 +: 2] = 2'd3; hwr_n = 4'b0000;
        hwr_data[1*DW +: DW] = 32'hA5A5_0001; hwr_en_n[4 +: 4] = 4'b0101;
        #2;
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL sw_idle_req: got %b expected 0", sdr_req); end
        cyc(); #2;
        checks++; if (hgnt !== 4'b0010) begin errors++; $display("FAIL sw_hgnt: got %b expected 0010", hgnt); end
        checks++; if (sdr_req !== 1'b1) begin errors++; $display("FAIL sw_req: got %b expected 1", sdr_req); end
        checks++; if ({sdr_req_adr, sdr_req_len, sdr_req_wr_n} !== {22'h000100, 2'd3, 1'b0}) begin
            errors++; $display("FAIL sw_fields: got %h/%0d/%b expected 000100/3/0", sdr_req_adr, sdr_req_len, sdr_req_wr_n); end
        checks++; if ({sdr_wr_data, sdr_wr_en_n} !== {32'hA5A5_0001, 4'b0101}) begin
            errors++; $display("FAIL sw_wdata: got %h/%b expected a5a50001/0101", sdr_wr_data, sdr_wr_en_n); end
        checks++; if (hack !== 4'b0) begin errors++; $display("FAIL sw_early_hack: got %b expected 0000", hack); end
        cyc();
        cyc(); sdr_req_ack = 1'b1; #2;
        checks++; if (hack !== 4'b0010) begin errors++; $display("FAIL sw_hack: got %b expected 0010", hack); end
        cyc(); sdr_req_ack = 1'b0; hreq = 4'b0;
        for (int k = 0; k < 4; k++) begin
            sdr_wr_next = 1'b1; #2;
            checks++; if (hwr_next !== 4'b0010) begin errors++; $display("FAIL sw_beat%0d: got %b expected 0010", k, hwr_next); end
            checks++; if (hgnt !== 4'b0010) begin errors++; $display("FAIL sw_hold%0d: got %b expected 0010", k, hgnt); end
            cyc();
        end
        sdr_wr_next = 1'b0; #2;
        checks++; if (hgnt !== 4'b0) begin errors++; $display("FAIL sw_release: got %b expected 0000", hgnt); end
        checks++; if (err_spur !== 1'b0) begin errors++; $display("FAIL sw_spur: got %b expected 0", err_spur); end
    endtask

    task automatic test_round_robin();
        logic [2:0] order [5];
        order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd2; order[3] = 3'd3; order[4] = 3'd0;
        reset_dut();
        hreq = 4'b1111; hlen = 8'h00; hwr_n = 4'b0000;
        for (int i = 0; i < NUM_REQ; i++) hadr[i*AW +: AW] = 22'(16 * i);
        for (int n = 0; n < 5; n++) begin
            cyc(); sdr_req_ack = 1'b1; #2;
            checks++; if (hgnt !== (4'b1 << order[n])) begin errors++; $display("FAIL rr_gnt%0d: got %b expected port %0d", n, hgnt, order[n]); end
            checks++; if ({sdr_req, sdr_req_adr} !== {1'b1, 22'(16 * order[n])}) begin
                errors++; $display("FAIL rr_req%0d: got %b/%h expected 1/%h", n, sdr_req, sdr_req_adr, 22'(16 * order[n])); end
            checks++; if (hack !== (4'b1 << order[n])) begin errors++; $display("FAIL rr_hack%0d: got %b", n, hack); end
            cyc(); sdr_req_ack = 1'b0; sdr_wr_next = 1'b1; #2;
            checks++; if (hwr_next !== (4'b1 << order[n])) begin errors++; $display("FAIL rr_beat%0d: got %b", n, hwr_next); end
            cyc(); sdr_wr_next = 1'b0;
            if (n == 4) hreq = 4'b0;
            #2;
            checks++; if ({sdr_req, hgnt} !== 5'b0) begin errors++; $display("FAIL rr_gap%0d: got %b/%b expected 0/0000", n, sdr_req, hgnt); end
        end
    endtask

    task automatic test_init_gating();
        int bad;
        bad = 0;
        sdr_init_done = 1'b0; hreq = 4'b0100; hwr_n = 4'b0100; hlen = 8'h00;
        for (int k = 0; k < 20; k++) begin
            cyc(); #2;
            if (sdr_req !== 1'b0 || hgnt !== 4'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL init_block: got %0d granted cycles expected 0", bad); end
        sdr_init_done = 1'b1;
        cyc(); #2;
        checks++; if (hgnt !== 4'b0100) begin errors++; $display("FAIL init_gnt: got %b expected 0100", hgnt); end
        sdr_req_ack = 1'b1;
        cyc(); sdr_req_ack = 1'b0; hreq = 4'b0; sdr_rd_valid = 1'b1; #2;
        checks++; if (hrd_valid !== 4'b0100) begin errors++; $display("FAIL init_rd: got %b expected 0100", hrd_valid); end
        cyc(); sdr_rd_valid = 1'b0;
    endtask

    task automatic test_read_spurious();
        hreq = 4'b1000; hwr_n = 4'b1000; hlen = 8'b01_00_00_00; hadr[3*AW +: AW] = 22'h3F0000;
        cyc();
        cyc(); sdr_req_ack = 1'b1; #2;
        checks++; if ({hgnt, sdr_req_wr_n, sdr_req_len} !== {4'b1000, 1'b1, 2'd1}) begin
            errors++; $display("FAIL rd_req: got %b/%b/%0d expected 1000/1/1", hgnt, sdr_req_wr_n, sdr_req_len); end
        cyc(); sdr_req_ack = 1'b0; hreq = 4'b0; sdr_rd_valid = 1'b1; sdr_rd_data = 32'h1111_2222; #2;
        checks++; if ({hrd_valid, hrd_data} !== {4'b1000, 32'h1111_2222}) begin
            errors++; $display("FAIL rd_beat0: got %b/%h expected 1000/11112222", hrd_valid, hrd_data); end
        cyc(); sdr_rd_data = 32'h3333_4444; #2;
        checks++; if ({hrd_valid, hrd_data} !== {4'b1000, 32'h3333_4444}) begin
            errors++; $display("FAIL rd_beat1: got %b/%h expected 1000/33334444", hrd_valid, hrd_data); end
        checks++; if (err_spur !== 1'b0) begin errors++; $display("FAIL rd_nospur: got %b expected 0", err_spur); end
        cyc(); #2;
        checks++; if ({hrd_valid, hgnt} !== 8'b0) begin errors++; $display("FAIL rd_spur_route: got %b/%b expected 0000/0000", hrd_valid, hgnt); end
        cyc(); sdr_rd_valid = 1'b0;
        cyc(); cyc(); #2;
        checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL rd_spur_flag: got %b expected 1", err_spur); end
    endtask

    task automatic test_watchdog();
        reset_dut();
        hreq = 4'b0011; hwr_n = 4'b0000; hlen = 8'h00;
        cyc(); sdr_req_ack = 1'b1;
        cyc(); sdr_req_ack = 1'b0; hreq = 4'b0010;
`ifdef SDC_ARB_WDOG_EN
        for (int k = 0; k < 400 && hgnt !== 4'b0010; k++) cyc();
        #2;
        checks++; if (hgnt !== 4'b0010) begin errors++; $display("FAIL wdog_next: got %b expected 0010", hgnt); end
        checks++; if (err_tmo !== 1'b1) begin errors++; $display("FAIL wdog_tmo: got %b expected 1", err_tmo); end
`else
        for (int k = 0; k < 300; k++) cyc();
        #2;
        checks++; if (hgnt !== 4'b0001) begin errors++; $display("FAIL wdog_hold: got %b expected 0001", hgnt); end
        checks++; if (err_tmo !== 1'b0) begin errors++; $display("FAIL wdog_tmo: got %b expected 0", err_tmo); end
`endif
        reset_dut();
    endtask

    task automatic test_reset_mid_burst();
        hreq = 4'b0100; hwr_n = 4'b0000; hlen = 8'b00_11_00_00; hadr[2*AW +: AW] = 22'h2AAAAA;
        cyc();
        cyc(); sdr_req_ack = 1'b1; #2;
        checks++; if (hack !== 4'b0100) begin errors++; $display("FAIL rst_hack: got %b expected 0100", hack); end
        cyc(); sdr_req_ack = 1'b0; hreq = 4'b0; sdr_wr_next = 1'b1;
        cyc(); s_reset = 1'b1; #2;
        checks++; if (hwr_next !== 4'b0100) begin errors++; $display("FAIL rst_beat2: got %b expected 0100", hwr_next); end
        cyc(); #2;
        checks++; if ({hgnt, sdr_req, hack, hwr_next, hrd_valid} !== 17'b0) begin
            errors++; $display("FAIL rst_outputs: got %b/%b/%b/%b/%b expected all 0", hgnt, sdr_req, hack, hwr_next, hrd_valid); end
        checks++; if ({sdr_req_adr, err_spur} !== 23'b0) begin errors++; $display("FAIL rst_adr_err: got %h/%b expected 0/0", sdr_req_adr, err_spur); end
        s_reset = 1'b0; sdr_wr_next = 1'b0; hreq = 4'b1111; hlen = 8'h00;
        cyc(); #2;
        checks++; if (hgnt !== 4'b0001) begin errors++; $display("FAIL rst_port0: got %b expected 0001", hgnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_init_gating();
        test_read_spurious();
        test_watchdog();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
